ltc2324_16_emu: RTL and testbench

- Synthesizable responder model of the LTC2324-16 quad 16-bit ADC serial interface, running entirely in the fabric clock domain.
- Accepts CNV and SCK from an ADC controller and returns CLKOUT and SDO1..SDO4 with LTC2324-style timing.
- Used for on-chip loopback testing of the sampling/DMA path without the real ADC.
- Each conversion's data comes either from four parallel input words or from an internal ramp pattern.

---
 rtl/ltc2324_16_emu.sv | 193 +++++++++++++++++++
 tb/tb_ltc2324_16_emu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2324_16_emu.sv
// ltc2324_16_emu: fabric-clock responder model of the LTC2324-16 quad ADC serial port.
// Ports:
//   clk, rst_n               fabric clock, asynchronous active-low reset
//   CNV, SCK                 controller strobes, asynchronous to clk
//   CLKOUT, SDO1..SDO4       echoed serial clock and per-channel MSB-first data
//   pattern_en, ch1..4_in    data source select (ramp / parallel words)
//   busy, conv_cnt           conversion phase flag, accepted-conversion count
//   early_cnv, err_clr       sticky CNV-while-busy flag and its synchronous clear
module ltc2324_16_emu #(
  parameter int unsigned TCONV_CYCLES = 24,
  parameter int unsigned SYNC_STAGES  = 2,   // must be >= 2
  parameter logic [15:0] RAMP_STEP    = 16'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CNV,
  input  logic        SCK,
  output logic        CLKOUT,
  output logic        SDO1,
  output logic        SDO2,
  output logic        SDO3,
  output logic        SDO4,
  input  logic        pattern_en,
  input  logic [15:0] ch1_in,
  input  logic [15:0] ch2_in,
  input  logic [15:0] ch3_in,
  input  logic [15:0] ch4_in,
  output logic        busy,
  output logic [15:0] conv_cnt,
  output logic        early_cnv,
  input  logic        err_clr
);

  localparam int unsigned DW  = 16;
  localparam int unsigned NCH = 4;
  localparam int unsigned BCW = 5;
  localparam int unsigned TCW = (TCONV_CYCLES > 1) ? $clog2(TCONV_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] cnv_sync_q, cnv_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic                   cnv_dly_q, cnv_dly_d;
  logic                   sck_dly_q, sck_dly_d;

  logic [NCH-1:0][DW-1:0] sr_q, sr_d;
  logic [NCH-1:0]         sdo_q, sdo_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [TCW-1:0]         tconv_q, tconv_d;
  logic [DW-1:0]          base_q, base_d;
  logic [DW-1:0]          conv_cnt_q, conv_cnt_d;
  logic                   busy_q, busy_d;
  logic                   early_q, early_d;

  logic cnv_rise_c;
  logic sck_fall_c;
  logic accept_c;
  logic tconv_done_c;
  logic last_bit_c;

  // Edge detects on the synchronized inputs; CNV is ignored while converting.
  assign cnv_rise_c   = cnv_sync_q[SYNC_STAGES-1] & ~cnv_dly_q;
  assign sck_fall_c   = ~sck_sync_q[SYNC_STAGES-1] & sck_dly_q;
  assign accept_c     = cnv_rise_c && (state_q != CONV);
  assign tconv_done_c = (tconv_q == TCW'(TCONV_CYCLES - 1));
  assign last_bit_c   = (bit_cnt_q == BCW'(DW - 1));

  assign CLKOUT    = sck_dly_q;
  assign SDO1      = sdo_q[0];
  assign SDO2      = sdo_q[1];
  assign SDO3      = sdo_q[2];
  assign SDO4      = sdo_q[3];
  assign busy      = busy_q;
  assign conv_cnt  = conv_cnt_q;
  assign early_cnv = early_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; an accepted CNV overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (accept_c) begin
      state_d = CONV;
    end else begin
      unique case (state_q)
        CONV:    if (tconv_done_c) state_d = SHIFT;
        SHIFT:   if (sck_fall_c && last_bit_c) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Output and datapath next values.
  always_comb begin
    cnv_sync_d = {cnv_sync_q[SYNC_STAGES-2:0], CNV};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], SCK};
    cnv_dly_d  = cnv_sync_q[SYNC_STAGES-1];
    sck_dly_d  = sck_sync_q[SYNC_STAGES-1];
    sr_d       = sr_q;
    sdo_d      = sdo_q;
    bit_cnt_d  = bit_cnt_q;
    tconv_d    = tconv_q;
    base_d     = base_q;
    conv_cnt_d = conv_cnt_q;
    busy_d     = busy_q;
    early_d    = early_q;

    // Set beats clear when both happen in one cycle.
    if (err_clr) early_d = 1'b0;
    if (cnv_rise_c && (state_q == CONV)) early_d = 1'b1;

    if (accept_c) begin
      for (int ch = 0; ch < NCH; ch++) begin
        sr_d[ch] = base_q + DW'(ch);
      end
      if (!pattern_en) begin
        sr_d[0] = ch1_in;
        sr_d[1] = ch2_in;
        sr_d[2] = ch3_in;
        sr_d[3] = ch4_in;
      end
      base_d     = base_q + RAMP_STEP;
      conv_cnt_d = conv_cnt_q + DW'(1);
      bit_cnt_d  = '0;
      tconv_d    = '0;
      busy_d     = 1'b1;
      sdo_d      = '0;
    end else begin
      unique case (state_q)
        CONV: begin
          if (tconv_done_c) begin
            busy_d  = 1'b0;
            tconv_d = '0;
            for (int ch = 0; ch < NCH; ch++) begin
              sdo_d[ch] = sr_q[ch][DW-1];
            end
          end else begin
            tconv_d = tconv_q + TCW'(1);
          end
        end
        SHIFT: begin
          // Data moves on SCK fall so it is stable at the following CLKOUT rise.
          if (sck_fall_c) begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            for (int ch = 0; ch < NCH; ch++) begin
              sr_d[ch]  = {sr_q[ch][DW-2:0], 1'b0};
              sdo_d[ch] = last_bit_c ? 1'b0 : sr_q[ch][DW-2];
            end
          end
        end
        default: sdo_d = '0;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnv_sync_q <= '0;
      sck_sync_q <= '0;
      cnv_dly_q  <= 1'b0;
      sck_dly_q  <= 1'b0;
      sr_q       <= '0;
      sdo_q      <= '0;
      bit_cnt_q  <= '0;
      tconv_q    <= '0;
      base_q     <= '0;
      conv_cnt_q <= '0;
      busy_q     <= 1'b0;
      early_q    <= 1'b0;
    end else begin
      cnv_sync_q <= cnv_sync_d;
      sck_sync_q <= sck_sync_d;
      cnv_dly_q  <= cnv_dly_d;
      sck_dly_q  <= sck_dly_d;
      sr_q       <= sr_d;
      sdo_q      <= sdo_d;
      bit_cnt_q  <= bit_cnt_d;
      tconv_q    <= tconv_d;
      base_q     <= base_d;
      conv_cnt_q <= conv_cnt_d;
      busy_q     <= busy_d;
      early_q    <= early_d;
    end
  end

endmodule

// File: tb/tb_ltc2324_16_emu.sv
// tb_ltc2324_16_emu: directed bench for ltc2324_16_emu acting as the ADC controller.
module tb_ltc2324_16_emu;

  logic        clk;
  logic        rst_n;
  logic        CNV;
  logic        SCK;
  logic        CLKOUT;
  logic        SDO1, SDO2, SDO3, SDO4;
  logic        pattern_en;
  logic [15:0] ch1_in, ch2_in, ch3_in, ch4_in;
  logic        busy;
  logic [15:0] conv_cnt;
  logic        early_cnv;
  logic        err_clr;

  int errors = 0;
  int checks = 0;

  ltc2324_16_emu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CNV        (CNV),
    .SCK        (SCK),
    .CLKOUT     (CLKOUT),
    .SDO1       (SDO1),
    .SDO2       (SDO2),
    .SDO3       (SDO3),
    .SDO4       (SDO4),
    .pattern_en (pattern_en),
    .ch1_in     (ch1_in),
    .ch2_in     (ch2_in),
    .ch3_in     (ch3_in),
    .ch4_in     (ch4_in),
    .busy       (busy),
    .conv_cnt   (conv_cnt),
    .early_cnv  (early_cnv),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse CNV and return how many clk cycles busy stayed high.
  task automatic do_conv(output int w);
    w = 0;
    @(negedge clk);
    CNV = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) w++;
      else if (w != 0) break;
      if (i == 3) CNV = 1'b0;
    end
    CNV = 1'b0;
  endtask

  // Issue n SCK pulses at clk/8; sample SDO after each CLKOUT rise.
  task automatic readout(input int n, output logic [15:0] w1, output logic [15:0] w2,
                         output logic [15:0] w3, output logic [15:0] w4,
                         output logic [3:0] extra, output int bad_dly);
    logic [3:0] b;
    int         dly;
    w1 = '0; w2 = '0; w3 = '0; w4 = '0;
    extra = '0;
    bad_dly = 0;
    for (int p = 0; p < n; p++) begin
      b   = '0;
      dly = 0;
      @(negedge clk);
      SCK = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (dly == 0 && CLKOUT) begin
          dly = k;
          b   = {SDO4, SDO3, SDO2, SDO1};
        end
      end
      SCK = 1'b0;
      repeat (3) @(negedge clk);
      if (dly != 3) bad_dly++;
      if (p < 16) begin
        w1 = {w1[14:0], b[0]};
        w2 = {w2[14:0], b[1]};
        w3 = {w3[14:0], b[2]};
        w4 = {w4[14:0], b[3]};
      end else begin
        extra = extra | b;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [15:0] r1, r2, r3, r4;
  logic [3:0]  ex;
  int          bad;
  int          bw;
  logic [15:0] exp_cnt;

  initial begin
    rst_n = 1'b0; CNV = 1'b0; SCK = 1'b0; err_clr = 1'b0; pattern_en = 1'b0;
    ch1_in = '0; ch2_in = '0; ch3_in = '0; ch4_in = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({CLKOUT, SDO1, SDO2, SDO3, SDO4, busy, early_cnv}), 64'd0);
    check("rst_conv_cnt", 64'(conv_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Parallel-input conversion.
    ch1_in = 16'hA5A5; ch2_in = 16'h0001; ch3_in = 16'h8000; ch4_in = 16'hFFFF;
    do_conv(bw);
    check("busy_width", 64'(bw), 64'd24);
    check("conv_cnt_1", 64'(conv_cnt), 64'd1);
    readout(16, r1, r2, r3, r4, ex, bad);
    check("par_data", {r1, r2, r3, r4}, 64'hA5A5_0001_8000_FFFF);
    check("clkout_delay_a", 64'(bad), 64'd0);

    // Ramp pattern from a fresh base.
    do_reset();
    pattern_en = 1'b1;
    do_conv(bw);
    readout(16, r1, r2, r3, r4, ex, bad);
    check("ramp_0", {r1, r2, r3, r4}, 64'h0000_0001_0002_0003);
    do_conv(bw);
    readout(16, r1, r2, r3, r4, ex, bad);
    check("ramp_1", {r1, r2, r3, r4}, 64'h0001_0002_0003_0004);
    do_conv(bw);
    readout(16, r1, r2, r3, r4, ex, bad);
    check("ramp_2", {r1, r2, r3, r4}, 64'h0002_0003_0004_0005);
    check("conv_cnt_3", 64'(conv_cnt), 64'd3);
    exp_cnt = 16'd3;

    // Second CNV edge 10 cycles into the conversion is ignored but flagged.
    pattern_en = 1'b0;
    ch1_in = 16'h1111; ch2_in = 16'h2222; ch3_in = 16'h3333; ch4_in = 16'h4444;
    @(negedge clk);
    CNV = 1'b1;
    repeat (3) @(negedge clk);
    CNV = 1'b0;
    ch1_in = 16'h9999; ch2_in = 16'h9999; ch3_in = 16'h9999; ch4_in = 16'h9999;
    repeat (7) @(negedge clk);
    CNV = 1'b1;
    repeat (3) @(negedge clk);
    CNV = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    check("early_set", 64'(early_cnv), 64'd1);
    check("early_cnt", 64'(conv_cnt), 64'(exp_cnt));
    readout(16, r1, r2, r3, r4, ex, bad);
    check("early_noreload", {r1, r2, r3, r4}, 64'h1111_2222_3333_4444);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("early_clr", 64'(early_cnv), 64'd0);

    // err_clr in the same cycle as a new early edge: flag stays set.
    @(negedge clk);
    CNV = 1'b1;
    repeat (3) @(negedge clk);
    CNV = 1'b0;
    repeat (7) @(negedge clk);
    CNV = 1'b1;
    @(negedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    CNV = 1'b0;
    check("early_set_wins", 64'(early_cnv), 64'd1);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    check("setwins_cnt", 64'(conv_cnt), 64'(exp_cnt));

    // Readout aborted after 7 bits by a new conversion.
    ch1_in = 16'hABCD;
    do_conv(bw);
    readout(7, r1, r2, r3, r4, ex, bad);
    ch1_in = 16'h1234;
    do_conv(bw);
    exp_cnt = exp_cnt + 16'd2;
    check("abort_busy", 64'(bw), 64'd24);
    readout(16, r1, r2, r3, r4, ex, bad);
    check("abort_ch1", 64'(r1), 64'h1234);
    check("abort_cnt", 64'(conv_cnt), 64'(exp_cnt));

    // Over-clocked readout: trailing bits are zero, CLKOUT keeps echoing.
    ch1_in = 16'hFFFF; ch2_in = 16'hFFFF; ch3_in = 16'h8001; ch4_in = 16'h7FFF;
    do_conv(bw);
    readout(20, r1, r2, r3, r4, ex, bad);
    check("over_data", {r1, r2, r3, r4}, 64'hFFFF_FFFF_8001_7FFF);
    check("over_extra", 64'(ex), 64'd0);
    check("over_clkout_delay", 64'(bad), 64'd0);

    // Asynchronous reset mid-conversion.
    @(negedge clk);
    CNV = 1'b1;
    repeat (8) @(negedge clk);
    CNV = 1'b0;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_conv_outs", 64'({CLKOUT, SDO1, SDO2, SDO3, SDO4, busy, early_cnv}), 64'd0);
    check("rst_conv_cnt", 64'(conv_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pattern_en = 1'b1;
    do_conv(bw);
    check("after_rst_busy", 64'(bw), 64'd24);
    check("after_rst_cnt", 64'(conv_cnt), 64'd1);
    readout(16, r1, r2, r3, r4, ex, bad);
    check("after_rst_ramp", {r1, r2, r3, r4}, 64'h0000_0001_0002_0003);

    // Asynchronous reset mid-readout with CLKOUT and SDO high.
    pattern_en = 1'b0;
    ch1_in = 16'hFFFF; ch2_in = 16'hFFFF; ch3_in = 16'hFFFF; ch4_in = 16'hFFFF;
    do_conv(bw);
    readout(3, r1, r2, r3, r4, ex, bad);
    @(negedge clk);
    SCK = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_rst_shift", 64'({CLKOUT, SDO1, SDO2, SDO3, SDO4}), 64'h1F);
    rst_n = 1'b0;
    #1;
    check("rst_shift_outs", 64'({CLKOUT, SDO1, SDO2, SDO3, SDO4, busy, early_cnv}), 64'd0);
    check("rst_shift_cnt", 64'(conv_cnt), 64'd0);
    SCK = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pattern_en = 1'b1;
    do_conv(bw);
    check("after_rst2_cnt", 64'(conv_cnt), 64'd1);
    readout(16, r1, r2, r3, r4, ex, bad);
    check("after_rst2_ramp", {r1, r2, r3, r4}, 64'h0000_0001_0002_0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
